fx_sub_sat: RTL and testbench

- Pipelined fixed-point subtractor that narrows its result back to the input format by saturation, so the output has the same width as the inputs.
- It is the counterpart to the datapath's widening adder, which grows one bit. This block computes a−b at full width and then clamps to DW bits.
- It sits between EKF arithmetic stages that need same-format operands, such as innovation and state-update differences. Both sides use a valid/ready stream.
- It reports every saturation event and keeps a sticky overflow flag and an event counter.

---
 rtl/fx_sub_sat.sv | 122 ++++++++++++
 tb/tb_fx_sub_sat.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_sub_sat.sv
// Saturating fixed-point subtractor: dout = clamp(a - b) back to the operand format.
// Latency: 2 cycles (S1 full-width difference, S2 saturation), 1 result per cycle.
// Backpressure: in_ready = !s1_valid | s2_adv; a stalled output holds dout/sat stable, nothing is dropped.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake for din_a (minuend) and din_b (subtrahend)
//   out_valid/out_ready   result handshake for dout and sat (sat = result was clamped)
//   ovf_sticky, sat_cnt   saturation statistics, updated on delivered results only
//   clr_stat              clears ovf_sticky and sat_cnt, wins over a same-cycle event
module fx_sub_sat #(
    parameter int SIGN_BIT = 1,
    parameter int INT_BIT  = 7,
    parameter int FLT_BIT  = 16,
    parameter int CNT_W    = 16,
    localparam int DW      = SIGN_BIT + INT_BIT + FLT_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    din_a,
    input  logic [DW-1:0]    din_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    dout,
    output logic             sat,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             clr_stat
);

    // S1 state: full-width difference
    logic          s1_vld_q;
    logic [DW:0]   s1_diff_q;
    logic [DW:0]   s1_diff_d;

    // S2 state: saturated result
    logic          out_vld_q;
    logic [DW-1:0] dout_q;
    logic [DW-1:0] dout_d;
    logic          sat_q;
    logic          sat_d;

    // statistics
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic s2_adv;
    logic sat_evt;

    assign s2_adv   = !out_vld_q || out_ready;
    // Gated by rst so the block advertises no space while being reset.
    assign in_ready = !rst && (!s1_vld_q || s2_adv);

    // One extra bit of headroom makes the difference exact for any operand pair.
    assign s1_diff_d = {din_a[DW-1], din_a} - {din_b[DW-1], din_b};

    // Top two bits disagree -> the result does not fit in DW bits.
    // The top bit is the true sign, so clamp towards it.
    always_comb begin
        sat_d  = 1'b0;
        dout_d = s1_diff_q[DW-1:0];
        if (s1_diff_q[DW] != s1_diff_q[DW-1]) begin
            sat_d  = 1'b1;
            dout_d = {s1_diff_q[DW], {(DW-1){~s1_diff_q[DW]}}};
        end
    end

    // Only results actually handed downstream are counted.
    assign sat_evt = out_vld_q && out_ready && sat_q;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_diff_q <= '0;
            out_vld_q <= 1'b0;
            dout_q    <= '0;
            sat_q     <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (in_ready) begin
                s1_vld_q <= in_valid;
                if (in_valid) begin
                    s1_diff_q <= s1_diff_d;
                end
            end

            if (s2_adv) begin
                out_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    dout_q <= dout_d;
                    sat_q  <= sat_d;
                end
            end

            if (clr_stat) begin
                ovf_q <= 1'b0;
                cnt_q <= '0;
            end else if (sat_evt) begin
                ovf_q <= 1'b1;
                cnt_q <= cnt_d;
            end
        end
    end

    assign out_valid  = out_vld_q;
    assign dout       = dout_q;
    assign sat        = sat_q;
    assign ovf_sticky = ovf_q;
    assign sat_cnt    = cnt_q;

endmodule

// File: tb/tb_fx_sub_sat.sv
// Directed bench for fx_sub_sat with a result scoreboard.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
// Expected results come from an integer reference of clamp(a - b) into signed 24-bit.
module tb_fx_sub_sat;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] din_a;
    logic [23:0] din_b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] dout;
    logic        sat;
    logic        ovf_sticky;
    logic [15:0] sat_cnt;
    logic        clr_stat;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    logic [24:0] exp_q[$];   // {sat, dout}

    fx_sub_sat dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_a     (din_a),
        .din_b     (din_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .sat       (sat),
        .ovf_sticky(ovf_sticky),
        .sat_cnt   (sat_cnt),
        .clr_stat  (clr_stat)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] model(input logic [23:0] a, input logic [23:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        if (d > 8388607)       return {1'b1, 24'h7FFFFF};
        else if (d < -8388608) return {1'b1, 24'h800000};
        else                   return {1'b0, d[23:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accepted input, pop and compare on delivered output.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_out observed dout=%0h with no pending expectation", dout);
                end
                if (exp_q.size() != 0) begin
                    logic [24:0] e;
                    e = exp_q.pop_front();
                    chk("dout", 32'(dout), 32'(e[23:0]));
                    chk("sat", 32'(sat), 32'(e[24]));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(din_a, din_b));
            end
        end
    end

    task automatic send(input logic [23:0] a, input logic [23:0] b);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        din_a = a;
        din_b = b;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        assert (acc === 1'b1) else begin
            errors++;
            $error("FAIL send_timeout observed accepted=%0d expected=1", acc);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        logic [24:0] hold;

        rst = 1'b1;
        in_valid = 1'b0;
        din_a = '0;
        din_b = '0;
        out_ready = 1'b0;
        clr_stat = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_ovf", 32'(ovf_sticky), 32'd0);
        chk("rst_cnt", 32'(sat_cnt), 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Basic subtraction and latency
        send(24'h010000, 24'h008000);
        chk("lat_c1", 32'(out_valid), 32'd0);
        tick();
        chk("lat_c2", 32'(out_valid), 32'd1);
        chk("basic_dout", 32'(dout), 32'h008000);
        send(24'h000000, 24'h000001);
        drain();
        chk("basic_cnt", 32'(sat_cnt), 32'd0);

        // Positive and negative saturation
        send(24'h7FFFFF, 24'hFFFFFF);
        drain();
        chk("pos_ovf", 32'(ovf_sticky), 32'd1);
        chk("pos_cnt", 32'(sat_cnt), 32'd1);
        send(24'h800000, 24'h000001);
        drain();
        chk("neg_cnt", 32'(sat_cnt), 32'd2);
        send(24'h800000, 24'h800000);
        drain();
        chk("zero_cnt", 32'(sat_cnt), 32'd2);

        // Backpressure: two accepts fill both stages, then input stalls
        n0 = n_out;
        out_ready = 1'b0;
        send(24'h000100, 24'h000001);
        send(24'h400000, 24'hC00000);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        hold = model(24'h000100, 24'h000001);
        chk("bp_dout", 32'(dout), 32'(hold[23:0]));
        in_valid = 1'b1;
        din_a = 24'h123456;
        din_b = 24'h023456;
        tick();
        tick();
        tick();
        chk("bp_in_ready_held", 32'(in_ready), 32'd0);
        chk("bp_dout_held", 32'(dout), 32'(hold[23:0]));
        chk("bp_sat_held", 32'(sat), 32'(hold[24]));
        out_ready = 1'b1;
        send(24'h123456, 24'h023456);
        send(24'hC00000, 24'h400001);
        drain();
        chk("bp_count", 32'(n_out - n0), 32'd4);
        chk("bp_cnt", 32'(sat_cnt), 32'd4);

        // Counter saturation at all-ones
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        chk("clr_cnt", 32'(sat_cnt), 32'd0);
        chk("clr_ovf", 32'(ovf_sticky), 32'd0);
        for (int i = 0; i < 65535; i++) begin
            send(24'h7FFFFF, 24'h800000);
        end
        drain();
        chk("full_cnt", 32'(sat_cnt), 32'hFFFF);
        chk("full_ovf", 32'(ovf_sticky), 32'd1);
        send(24'h800000, 24'h7FFFFF);
        drain();
        chk("hold_cnt", 32'(sat_cnt), 32'hFFFF);

        // Clear coinciding with a saturating delivery
        send(24'h7FFFFF, 24'hFFFFFF);
        tick();
        chk("clr_coinc_valid", 32'(out_valid), 32'd1);
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        chk("clr_coinc_cnt", 32'(sat_cnt), 32'd0);
        chk("clr_coinc_ovf", 32'(ovf_sticky), 32'd0);

        // Reset mid-stream with both stages full
        send(24'h7FFFFF, 24'hFFFFFF);
        drain();
        chk("pre_rst_cnt", 32'(sat_cnt), 32'd1);
        out_ready = 1'b0;
        send(24'h000010, 24'h000001);
        send(24'h000020, 24'h000001);
        chk("mid_full", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_cnt", 32'(sat_cnt), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        send(24'h000300, 24'h000100);
        chk("post_lat_c1", 32'(out_valid), 32'd0);
        tick();
        chk("post_lat_c2", 32'(out_valid), 32'd1);
        chk("post_dout", 32'(dout), 32'h000200);
        drain();
        chk("post_count", 32'(n_out - n0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
